// File: rtl/audio_pkg.sv
// -----------------------------------------------------------------------------
// audio_pkg
// Constants and types shared by the WM8978 I2S transmit and receive paths:
//   AUD_WL_DEFAULT      default audio word length in bits (legal 16..32)
//   AUD_CNT_W           width of the per-frame bit counter
//   AUD_CNT_SAT         bit counter saturation value
//   AUD_CNT_FRAME_START bit counter value on the bclk edge that sees an LRC edge
//   aud_frame_act_t     action taken at a bclk rising edge
//   aud_cnt_next()      bit counter next-state helper
// -----------------------------------------------------------------------------
package audio_pkg;

  localparam logic [5:0]  AUD_WL_DEFAULT = 6'd32;
  localparam int unsigned AUD_CNT_W      = 6;

  localparam logic [AUD_CNT_W-1:0] AUD_CNT_SAT         = 6'd35;
  localparam logic [AUD_CNT_W-1:0] AUD_CNT_FRAME_START = '0;

  typedef enum logic [1:0] {
    FRAME_RUN,       // mid-frame, keep shifting
    FRAME_LOAD,      // frame start with a word held
    FRAME_UNDERRUN   // frame start with nothing held
  } aud_frame_act_t;

  // Counter restarts on every LRC edge and parks at the saturation value so a
  // long LRC half-period never wraps back into the data window.
  function automatic logic [AUD_CNT_W-1:0] aud_cnt_next(
    input logic [AUD_CNT_W-1:0] cnt,
    input logic                 frame_start
  );
    if (frame_start)         return AUD_CNT_FRAME_START;
    if (cnt >= AUD_CNT_SAT)  return AUD_CNT_SAT;
    return cnt + 6'd1;
  endfunction

endpackage

// File: rtl/audio_lrc_edge.sv
// -----------------------------------------------------------------------------
// audio_lrc_edge
// Registers the WM8978 LRC clock on the bit clock and flags either transition.
// Shared between the transmit and receive paths.
// Ports:
//   aud_bclk  in   bit clock
//   rst_n     in   asynchronous active-low reset
//   aud_lrc   in   left/right alignment clock
//   lrc_edge  out  high for the bclk cycle in which aud_lrc differs from lrc_d0
// -----------------------------------------------------------------------------
module audio_lrc_edge (
  input  logic aud_bclk,
  input  logic rst_n,
  input  logic aud_lrc,
  output logic lrc_edge
);

  logic lrc_d0;

  always_ff @(posedge aud_bclk or negedge rst_n) begin
    if (!rst_n) begin
      lrc_d0 <= 1'b0;
    end else begin
      lrc_d0 <= aud_lrc;
    end
  end

  assign lrc_edge = aud_lrc ^ lrc_d0;

endmodule

// File: rtl/audio_send.sv
// -----------------------------------------------------------------------------
// audio_send
// I2S serialiser for the WM8978 DAC. A single-entry holding register accepts
// user words through a valid/ready handshake; each LRC transition starts a new
// frame, moving the held word into the shift register (or underrunning when
// none is held). Data changes on the bclk falling edge, MSB first, one bclk
// after the LRC transition.
// Parameters:
//   WL          audio word length, 16..32, sample MSB-aligned at bit WL-1
// Ports:
//   aud_bclk    in   WM8978 bit clock (sole clock)
//   rst_n       in   asynchronous active-low reset
//   aud_lrc     in   WM8978 left/right alignment clock
//   aud_dacdat  out  serial data to the DAC
//   dac_data    in   user sample
//   dac_valid   in   dac_data is valid
//   dac_ready   out  holding register can accept a word (registered)
//   tx_done     out  one-cycle pulse when a held word starts shifting out
//   underrun    out  one-cycle pulse when a frame starts with no word held
// Build option:
//   AUDIO_SEND_UNDERRUN_HOLD_EN  underrun repeats the last transmitted word
//                                instead of sending zeros
// -----------------------------------------------------------------------------
module audio_send
  import audio_pkg::*;
#(
  parameter logic [5:0] WL = AUD_WL_DEFAULT
) (
  input  logic        aud_bclk,
  input  logic        rst_n,
  input  logic        aud_lrc,
  output logic        aud_dacdat,
  input  logic [31:0] dac_data,
  input  logic        dac_valid,
  output logic        dac_ready,
  output logic        tx_done,
  output logic        underrun
);

  logic                 lrc_edge;
  logic [AUD_CNT_W-1:0] tx_cnt;
  logic [31:0]          shift_reg;
  logic [31:0]          shift_nxt;
  logic [31:0]          hold_reg;
  logic                 hold_valid;
  logic                 hold_valid_nxt;
  logic                 ready_q;
  logic                 tx_done_q;
  logic                 underrun_q;
  logic                 dacdat_q;
  logic                 accept;
  logic                 tx_bit;
  logic [4:0]           bit_idx;
  aud_frame_act_t       frame_act;

  audio_lrc_edge u_lrc_edge (
    .aud_bclk (aud_bclk),
    .rst_n    (rst_n),
    .aud_lrc  (aud_lrc),
    .lrc_edge (lrc_edge)
  );

  // Frame start is decided from hold_valid before this edge's accept, so a
  // word accepted on the LRC edge itself waits for the following frame.
  always_comb begin
    frame_act      = FRAME_RUN;
    accept         = dac_valid && ready_q;
    hold_valid_nxt = hold_valid;
    shift_nxt      = shift_reg;

    if (lrc_edge) begin
      frame_act = hold_valid ? FRAME_LOAD : FRAME_UNDERRUN;
    end

    case (frame_act)
      FRAME_LOAD: begin
        shift_nxt      = hold_reg;
        hold_valid_nxt = 1'b0;
      end
      FRAME_UNDERRUN: begin
`ifdef AUDIO_SEND_UNDERRUN_HOLD_EN
        // shift_reg is indexed, never shifted, so it still holds the last word
        shift_nxt = shift_reg;
`else
        shift_nxt = '0;
`endif
      end
      default: ;
    endcase

    if (accept) begin
      hold_valid_nxt = 1'b1;
    end
  end

  always_ff @(posedge aud_bclk or negedge rst_n) begin
    if (!rst_n) begin
      tx_cnt     <= '0;
      shift_reg  <= '0;
      hold_reg   <= '0;
      hold_valid <= 1'b0;
      ready_q    <= 1'b1;
      tx_done_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      tx_cnt     <= aud_cnt_next(tx_cnt, lrc_edge);
      shift_reg  <= shift_nxt;
      if (accept) begin
        hold_reg <= dac_data;
      end
      hold_valid <= hold_valid_nxt;
      ready_q    <= ~hold_valid_nxt;
      tx_done_q  <= (frame_act == FRAME_LOAD);
      underrun_q <= (frame_act == FRAME_UNDERRUN);
    end
  end

  // Output bit for the current count; bits past the word length are zero.
  assign bit_idx = 5'(WL - 6'd1 - tx_cnt);
  assign tx_bit  = (tx_cnt < WL) ? shift_reg[bit_idx] : 1'b0;

  always_ff @(negedge aud_bclk or negedge rst_n) begin
    if (!rst_n) begin
      dacdat_q <= 1'b0;
    end else begin
      dacdat_q <= tx_bit;
    end
  end

  assign aud_dacdat = dacdat_q;
  assign dac_ready  = ready_q;
  assign tx_done    = tx_done_q;
  assign underrun   = underrun_q;

endmodule
